// File: rtl/program_loader_pkg.sv
// Shared definitions for the programming path: width defaults common to the
// control unit, instruction memory and loader, plus the loader FSM encoding.
package program_loader_pkg;

  localparam int REGISTER_WIDTH       = 4;
  localparam int MEMORY_ADDRESS_WIDTH = 4;
  localparam int ACK_TIMEOUT_DEFAULT  = 15;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_REQ     = ST_REQ,
    S_LOAD    = ST_LOAD,
    S_WRITE   = ST_WRITE,
    S_RELEASE = ST_RELEASE,
    S_DONE    = ST_DONE,
    S_ERROR   = ST_ERROR
  } state_t;

  // Wide enough to hold counts up to the acknowledge timeout limit.
  function automatic int timeout_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int TIMEOUT_WIDTH = timeout_width(ACK_TIMEOUT_DEFAULT);

endpackage

// File: rtl/program_loader_if.sv
// Loader-facing bundle: the nibble source stream and the control unit's
// programming port. master = the loader, slave = source + control unit side.
interface program_loader_if #(
  parameter int REGISTER_WIDTH       = program_loader_pkg::REGISTER_WIDTH,
  parameter int MEMORY_ADDRESS_WIDTH = program_loader_pkg::MEMORY_ADDRESS_WIDTH
);

  // Source stream: a nibble transfers on every clock edge where s_valid_i and
  // s_ready_o are both 1; s_data_i/s_last_i are meaningful only on that edge,
  // and the source holds them stable while s_valid_i waits for s_ready_o.
  logic [REGISTER_WIDTH-1:0]       s_data_i;
  logic                            s_valid_i;
  logic                            s_last_i;
  logic                            s_ready_o;

  logic                            p_program_o;
  logic                            p_active_i;
  logic                            p_write_en_mem_o;
  logic [MEMORY_ADDRESS_WIDTH-1:0] p_address_o;
  logic [REGISTER_WIDTH-1:0]       p_data_o;

  modport master (
    input  s_data_i, s_valid_i, s_last_i, p_active_i,
    output s_ready_o, p_program_o, p_write_en_mem_o, p_address_o, p_data_o
  );

  modport slave (
    output s_data_i, s_valid_i, s_last_i, p_active_i,
    input  s_ready_o, p_program_o, p_write_en_mem_o, p_address_o, p_data_o
  );

endinterface

// File: rtl/program_loader.sv
// Programmer-side master: requests program mode, streams source nibbles into
// instruction memory from address 0 upward, then releases the CPU.
module program_loader #(
  parameter int REGISTER_WIDTH       = program_loader_pkg::REGISTER_WIDTH,
  parameter int MEMORY_ADDRESS_WIDTH = program_loader_pkg::MEMORY_ADDRESS_WIDTH,
  parameter int ACK_TIMEOUT          = program_loader_pkg::ACK_TIMEOUT_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          start_i,
  program_loader_if.master              bus,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic [MEMORY_ADDRESS_WIDTH:0] words_o,
  output program_loader_pkg::state_t    state_o
);

  import program_loader_pkg::*;

  localparam int TW = timeout_width(ACK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_MAX = '1;

  state_t                          state_q, state_d;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q;
  logic [REGISTER_WIDTH-1:0]       data_q;
  logic [MEMORY_ADDRESS_WIDTH:0]   words_q;
  logic                            last_q;
  logic                            error_q;
  logic [TW-1:0]                   tmo_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_REQ;
      S_REQ: begin
        if (bus.p_active_i)       state_d = S_LOAD;
        else if (tmo_q == TMO_LAST) state_d = S_ERROR;
      end
      // Losing program mode mid-stream aborts before any further write.
      S_LOAD: begin
        if (!bus.p_active_i)      state_d = S_ERROR;
        else if (bus.s_valid_i)   state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!bus.p_active_i)                 state_d = S_ERROR;
        else if (last_q || addr_q == ADDR_MAX) state_d = S_RELEASE;
        else                                 state_d = S_LOAD;
      end
      S_RELEASE: begin
        if (!bus.p_active_i)      state_d = S_DONE;
        else if (tmo_q == TMO_LAST) state_d = S_ERROR;
      end
      S_DONE:    state_d = S_IDLE;
      S_ERROR:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      words_q <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;

      // Counter restarts on every state change, so it is zero on REQ/RELEASE entry.
      if (state_d != state_q)
        tmo_q <= '0;
      else if (state_q == S_REQ || state_q == S_RELEASE)
        tmo_q <= tmo_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q  <= '0;
            words_q <= '0;
            last_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (state_d == S_WRITE) begin
            data_q <= bus.s_data_i;
            last_q <= bus.s_last_i;
          end
        end
        S_WRITE: begin
          words_q <= words_q + 1'b1;
          if (state_d == S_LOAD) addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase

      if (state_d == S_ERROR) error_q <= 1'b1;
    end
  end

  // Every p_* output is either a register or a pure decode of state_q.
  assign bus.s_ready_o        = (state_q == S_LOAD);
  assign bus.p_program_o      = (state_q == S_REQ) || (state_q == S_LOAD) || (state_q == S_WRITE);
  assign bus.p_write_en_mem_o = (state_q == S_WRITE);
  assign bus.p_address_o      = addr_q;
  assign bus.p_data_o         = data_q;

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE);
  assign error_o = error_q;
  assign words_o = words_q;
  assign state_o = state_q;

endmodule
